// File: rtl/conv_pkg.sv
// Shared types for the convolution configuration sequencer.
package conv_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_EVAL_IW = 3'd1,
      S_EVAL_KW = 3'd2,
      S_READ_M0 = 3'd3,
      S_READ_CN = 3'd4,
      S_READ_K  = 3'd5,
      S_DONE    = 3'd6
   } conv_seq_state_e;

   // One extra bit so an index counter can reach its word count without wrapping.
   function automatic int unsigned idx_w(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/conv_beat_cnt.sv
// Beat counter with synchronous clear, increment and a terminal-value compare.
module conv_beat_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_inc,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_cnt,
   output logic         o_term
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_term = (r_cnt == i_last);

endmodule

// File: rtl/conv_cfg_sequencer.sv
// Configuration sequencer: evaluates dimensions through the multiplier, then
// streams M0 words, one C/N word and a run-time-sized kernel from memory.
module conv_cfg_sequencer
   import conv_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned M0_WORDS = 2,
   parameter int unsigned LEN_W    = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_begin,
   input  logic                          i_abort,
   input  logic [LEN_W-1:0]              i_k_len,
   output logic                          o_mul_valid,
   input  logic                          i_mul_ready,
   input  logic                          i_mul_done,
   output logic                          o_mem_ready,
   input  logic                          i_mem_valid,
   output logic                          o_enb_axisreg,
   output logic                          o_enb_mul,
   output logic                          o_enb_result,
   output logic                          o_enb_m0,
   output logic [idx_w(M0_WORDS)-1:0]    o_m0_idx,
   output logic                          o_enb_cn,
   output logic                          o_enb_k,
   output logic [LEN_W-1:0]              o_k_idx,
   output logic                          o_busy,
   output logic                          o_done
);

   localparam int unsigned M0_IW = idx_w(M0_WORDS);
   localparam logic [M0_IW-1:0] M0_LAST = M0_IW'(M0_WORDS - 1);

   // DATA_W is informational only: no data word passes through this block.
   if (DATA_W == 0 || M0_WORDS == 0) begin : g_param_guard
   end

   conv_seq_state_e    r_state;
   conv_seq_state_e    w_next;
   logic               r_issued;
   logic [LEN_W-1:0]   r_k_len;

   logic               w_abort;
   logic               w_eval;
   logic               w_read;
   logic               w_beat;
   logic               w_cnt_clr;
   logic               w_m0_term;
   logic               w_k_term;
   logic [M0_IW-1:0]   w_m0_cnt;
   logic [LEN_W-1:0]   w_k_cnt;

   assign w_abort = i_abort && (r_state != S_IDLE);
   assign w_eval  = (r_state == S_EVAL_IW) || (r_state == S_EVAL_KW);
   assign w_read  = (r_state == S_READ_M0) || (r_state == S_READ_CN) || (r_state == S_READ_K);

   // Abort masks every handshake and enable in its own cycle.
   assign o_mul_valid   = w_eval && !r_issued && !w_abort;
   assign o_mem_ready   = w_read && !w_abort;
   assign w_beat        = i_mem_valid && o_mem_ready;

   assign o_enb_axisreg = (r_state == S_IDLE) && i_begin;
   assign o_enb_mul     = (r_state == S_EVAL_KW) && o_mul_valid;
   assign o_enb_result  = w_eval && r_issued && i_mul_done && !w_abort;
   assign o_enb_m0      = (r_state == S_READ_M0) && w_beat;
   assign o_enb_cn      = (r_state == S_READ_CN) && w_beat;
   assign o_enb_k       = (r_state == S_READ_K) && w_beat;
   assign o_m0_idx      = w_m0_cnt;
   assign o_k_idx       = w_k_cnt;
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_DONE) && !i_abort;

   assign w_cnt_clr = w_abort || (r_state == S_DONE);

   conv_beat_cnt #(.W(M0_IW)) u_m0_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_cnt_clr),
      .i_inc  (o_enb_m0),
      .i_last (M0_LAST),
      .o_cnt  (w_m0_cnt),
      .o_term (w_m0_term)
   );

   conv_beat_cnt #(.W(LEN_W)) u_k_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_cnt_clr),
      .i_inc  (o_enb_k),
      .i_last (r_k_len - 1'b1),
      .o_cnt  (w_k_cnt),
      .o_term (w_k_term)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (i_begin) w_next = S_EVAL_IW;
         S_EVAL_IW: if (o_enb_result) w_next = S_EVAL_KW;
         S_EVAL_KW: if (o_enb_result) w_next = S_READ_M0;
         S_READ_M0: if (o_enb_m0 && w_m0_term) w_next = S_READ_CN;
         S_READ_CN: if (o_enb_cn) w_next = (r_k_len != '0) ? S_READ_K : S_DONE;
         S_READ_K:  if (o_enb_k && w_k_term) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_issued <= 1'b0;
         r_k_len  <= '0;
      end else begin
         r_state <= w_next;
         // Any state change re-arms the multiplier request for the next phase.
         if (w_next != r_state) begin
            r_issued <= 1'b0;
         end else if (o_mul_valid && i_mul_ready) begin
            r_issued <= 1'b1;
         end
         if (o_enb_axisreg) begin
            r_k_len <= i_k_len;
         end
      end
   end

endmodule

// File: tb/tb_conv_cfg_sequencer.sv
// Self-checking bench for conv_cfg_sequencer: vector table, randomized runs
// and hand-written abort / asynchronous-reset sequences.
module tb_conv_cfg_sequencer;

   localparam int unsigned M0_WORDS = 2;
   localparam int unsigned LEN_W    = 12;
   localparam int unsigned M0_IW    = $clog2(M0_WORDS) + 1;
   localparam int          BUDGET   = 20000;

   logic               clk;
   logic               rst;
   logic               i_begin;
   logic               i_abort;
   logic [LEN_W-1:0]   i_k_len;
   logic               o_mul_valid;
   logic               i_mul_ready;
   logic               i_mul_done;
   logic               o_mem_ready;
   logic               i_mem_valid;
   logic               o_enb_axisreg;
   logic               o_enb_mul;
   logic               o_enb_result;
   logic               o_enb_m0;
   logic [M0_IW-1:0]   o_m0_idx;
   logic               o_enb_cn;
   logic               o_enb_k;
   logic [LEN_W-1:0]   o_k_idx;
   logic               o_busy;
   logic               o_done;

   conv_cfg_sequencer #(
      .DATA_W   (32),
      .M0_WORDS (M0_WORDS),
      .LEN_W    (LEN_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_begin       (i_begin),
      .i_abort       (i_abort),
      .i_k_len       (i_k_len),
      .o_mul_valid   (o_mul_valid),
      .i_mul_ready   (i_mul_ready),
      .i_mul_done    (i_mul_done),
      .o_mem_ready   (o_mem_ready),
      .i_mem_valid   (i_mem_valid),
      .o_enb_axisreg (o_enb_axisreg),
      .o_enb_mul     (o_enb_mul),
      .o_enb_result  (o_enb_result),
      .o_enb_m0      (o_enb_m0),
      .o_m0_idx      (o_m0_idx),
      .o_enb_cn      (o_enb_cn),
      .o_enb_k       (o_enb_k),
      .o_k_idx       (o_k_idx),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int k_len;
      int valid_pct;
      int stall;
      bit spurious;
      bit abort_at_begin;
      int exp_lat;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus knobs
   bit drv_begin, drv_abort, rand_begin, spurious, mul_pend;
   int valid_pct, stall_left, cyc;

   // observations
   int m0_q[$];
   int k_q[$];
   int axis_n, res_n, mul_n, cn_n, done_n, done_cyc, mulv_n, viol_n;
   bit s_busy, s_mem_ready, s_mul_valid, s_enb_k;

   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({o_mul_valid, o_mem_ready, o_enb_axisreg, o_enb_mul, o_enb_result,
                  o_enb_m0, o_enb_cn, o_enb_k, o_busy, o_done, o_m0_idx, o_k_idx});
   endfunction

   task automatic clear_obs();
      m0_q.delete();
      k_q.delete();
      axis_n = 0; res_n = 0; mul_n = 0; cn_n = 0; done_n = 0;
      done_cyc = -1; mulv_n = 0; viol_n = 0; cyc = 0;
   endtask

   // One clock cycle: drive inputs after the edge, sample at the falling edge.
   task automatic tick();
      i_begin     = drv_begin | (rand_begin && ($urandom_range(3) == 0));
      i_abort     = drv_abort;
      i_mem_valid = ($urandom_range(99) < valid_pct);
      i_mul_ready = (stall_left == 0);
      i_mul_done  = mul_pend | (spurious && stall_left > 0);
      @(negedge clk);
      if (o_enb_axisreg) axis_n++;
      if (o_enb_result) res_n++;
      if (o_enb_mul) mul_n++;
      if (o_enb_cn) cn_n++;
      if (o_enb_m0) m0_q.push_back(int'(o_m0_idx));
      if (o_enb_k) k_q.push_back(int'(o_k_idx));
      if (o_done) begin
         done_n++;
         done_cyc = cyc;
      end
      if (cyc >= 1 && stall_left > 0 && o_mul_valid) mulv_n++;
      if ((o_enb_m0 || o_enb_cn || o_enb_k) && !i_mem_valid) viol_n++;
      if (o_enb_result && !i_mul_done) viol_n++;
      s_busy      = o_busy;
      s_mem_ready = o_mem_ready;
      s_mul_valid = o_mul_valid;
      s_enb_k     = o_enb_k;
      // multiplier model: result one cycle after acceptance
      if (i_mul_done && mul_pend) mul_pend = 1'b0;
      if (o_mul_valid && i_mul_ready) mul_pend = 1'b1;
      if (i_abort) mul_pend = 1'b0;
      if (cyc >= 1 && stall_left > 0) stall_left--;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int k_len, input bit abort_too);
      clear_obs();
      drv_begin = 1'b1;
      drv_abort = abort_too;
      i_k_len   = LEN_W'(k_len);
      tick();
      drv_begin = 1'b0;
      drv_abort = 1'b0;
      i_k_len   = LEN_W'($urandom);
   endtask

   task automatic run_seq(input vec_t v, input string tag);
      int bad;
      valid_pct  = v.valid_pct;
      stall_left = v.stall;
      spurious   = v.spurious;
      rand_begin = (v.exp_lat < 0);
      start(v.k_len, v.abort_at_begin);
      for (int i = 0; i < BUDGET && done_n == 0; i++) tick();
      rand_begin = 1'b0;
      spurious   = 1'b0;
      tick();
      tick();
      check({tag, ".done_count"}, done_n, 1);
      check({tag, ".axis_count"}, axis_n, 1);
      check({tag, ".result_count"}, res_n, 2);
      check({tag, ".enb_mul_count"}, mul_n, 1);
      check({tag, ".cn_count"}, cn_n, 1);
      check({tag, ".m0_count"}, m0_q.size(), M0_WORDS);
      bad = 0;
      foreach (m0_q[i]) if (m0_q[i] != i) bad++;
      check({tag, ".m0_idx_order"}, bad, 0);
      check({tag, ".k_count"}, k_q.size(), v.k_len);
      bad = 0;
      foreach (k_q[i]) if (k_q[i] != i) bad++;
      check({tag, ".k_idx_order"}, bad, 0);
      check({tag, ".handshake_violations"}, viol_n, 0);
      check({tag, ".busy_after"}, s_busy, 0);
      if (v.exp_lat >= 0) check({tag, ".latency"}, done_cyc, v.exp_lat);
      if (v.stall > 0) check({tag, ".mul_valid_held"}, mulv_n, v.stall);
   endtask

   vec_t vecs[6];
   vec_t rv;

   initial begin
      // k_len, valid%, mul stall, spurious done, abort with begin, latency
      vecs[0] = '{4,    100, 0, 1'b0, 1'b0, 12};
      vecs[1] = '{0,    100, 0, 1'b0, 1'b0, 8};
      vecs[2] = '{4,    100, 5, 1'b1, 1'b0, 17};
      vecs[3] = '{1,    100, 0, 1'b0, 1'b1, 9};
      vecs[4] = '{9,    50,  0, 1'b0, 1'b0, -1};
      vecs[5] = '{4095, 100, 0, 1'b0, 1'b0, 4103};

      drv_begin = 0; drv_abort = 0; rand_begin = 0; spurious = 0; mul_pend = 0;
      valid_pct = 0; stall_left = 0;
      i_begin = 0; i_abort = 0; i_k_len = '0; i_mul_ready = 0; i_mul_done = 0;
      i_mem_valid = 0;
      clear_obs();

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.outputs", all_outs(), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      tick();
      check("idle.busy", s_busy, 0);

      foreach (vecs[i]) run_seq(vecs[i], $sformatf("vec%0d", i));

      for (int n = 0; n < 6; n++) begin
         rv.k_len          = $urandom_range(20, 0);
         rv.valid_pct      = $urandom_range(100, 30);
         rv.stall          = $urandom_range(4, 0);
         rv.spurious       = 1'($urandom_range(1));
         rv.abort_at_begin = 1'($urandom_range(1));
         rv.exp_lat        = -1;
         run_seq(rv, $sformatf("rnd%0d", n));
      end

      // abort in READ_K after index 3 has been written
      valid_pct = 100; stall_left = 0; spurious = 0; rand_begin = 0;
      start(8, 1'b0);
      for (int i = 0; i < 200 && k_q.size() < 4; i++) tick();
      check("abort.k_before", k_q.size(), 4);
      drv_abort = 1'b1;
      tick();
      drv_abort = 1'b0;
      check("abort.no_k_beat", k_q.size(), 4);
      check("abort.mem_ready", s_mem_ready, 0);
      check("abort.busy_in_cycle", s_busy, 1);
      tick();
      check("abort.idle_next", s_busy, 0);
      repeat (3) tick();
      check("abort.no_done", done_n, 0);
      run_seq(vecs[0], "restart");

      // asynchronous reset in READ_M0
      valid_pct = 100; stall_left = 0; spurious = 0; rand_begin = 0;
      start(4, 1'b0);
      for (int i = 0; i < 200 && m0_q.size() < 1; i++) tick();
      check("arst.in_m0", m0_q.size(), 1);
      i_mem_valid = 1'b1;
      #1;
      check("arst.mem_ready_before", o_mem_ready, 1);
      #1;
      rst = 1'b1;
      #1;
      check("arst.outputs", all_outs(), 0);
      check("arst.busy", o_busy, 0);
      @(negedge clk);
      rst = 1'b0;
      mul_pend = 1'b0;
      @(posedge clk);
      #1;
      run_seq(vecs[1], "after_arst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_cfg_sequencer.md
# conv_cfg_sequencer

Parametrised configuration sequencer for the convolution engine, succeeding the fixed seven-state conv controller. On a start request it:
- evaluates input and kernel widths through a handshaked multiplier (peasant) unit;
- streams a configurable number of M0 words, one C/N word and a run-time-sized kernel from the memory stream.

It counts kernel beats internally, supports abort, and reports completion. It sits between the top-level command interface and the datapath register enables.

## Interface
Parameters:
- DATA_W, 32, memory stream word width (informational; no data passes through this block)
- M0_WORDS, 2, number of M0 words read (≥1)
- LEN_W, 12, width of kernel word count and kernel index

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_begin  in  1  start request, sampled only in IDLE
- i_abort  in  1  abandon current sequence
- i_k_len  in  LEN_W  kernel length in memory words, latched on accepted i_begin
- o_mul_valid  out  1  request to multiplier
- i_mul_ready  in  1  multiplier accepts request
- i_mul_done  in  1  multiplier result valid
- o_mem_ready  out  1  sink ready toward memory stream
- i_mem_valid  in  1  memory word valid
- o_enb_axisreg  out  1  capture input dimensions register
- o_enb_mul  out  1  load multiplier operands (kernel-width phase)
- o_enb_result  out  1  capture multiplier result
- o_enb_m0  out  1  write M0 word
- o_m0_idx  out  $clog2(M0_WORDS)+1  index of M0 word being written
- o_enb_cn  out  1  write C/N register
- o_enb_k  out  1  write kernel word
- o_k_idx  out  LEN_W  index of kernel word being written
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, EVAL_IW, EVAL_KW, READ_M0, READ_CN, READ_K, DONE.
- IDLE:
  - i_begin → EVAL_IW; o_enb_axisreg = i_begin (combinational).
  - i_k_len is latched into k_len on the same edge.
- EVAL_IW / EVAL_KW:
  - Internal flag issued clears on state entry.
  - o_mul_valid = !issued; issued sets on o_mul_valid && i_mul_ready.
  - o_enb_mul = (EVAL_KW && o_mul_valid).
  - When issued && i_mul_done: o_enb_result = 1 and the block advances (IW → KW → READ_M0).
  - i_mul_done while !issued is ignored.
- Memory beat = i_mem_valid && o_mem_ready. o_mem_ready = 1 in READ_M0, READ_CN and READ_K.
- READ_M0:
  - o_enb_m0 = beat; o_m0_idx = m0 counter.
  - The counter increments per beat; the beat with counter == M0_WORDS-1 → READ_CN.
- READ_CN: o_enb_cn = beat. On a beat, go to READ_K if k_len ≠ 0, else go to DONE.
- READ_K:
  - o_enb_k = beat; o_k_idx = k counter.
  - The beat with counter == k_len-1 → DONE.
- DONE: o_done = 1 for one cycle → IDLE; counters and issued clear.
- i_abort (any non-IDLE state) overrides all transitions:
  - → IDLE next cycle, counters cleared, no o_done.
  - In the abort cycle all enables and o_mem_ready/o_mul_valid are forced 0.
- i_begin outside IDLE is ignored. i_abort in IDLE has no effect.

## Timing
- Reset value: every output 0, state IDLE, counters 0, issued 0, k_len 0.
- All enables are combinational from state and inputs in the same cycle as the accepted beat or result. State and counters update on the following edge.
- Minimum EVAL phase is 2 cycles (accept, then done).
- Zero-wait total from i_begin to o_done = 1 + 2 + 2 + M0_WORDS + 1 + k_len + 1 cycles (k_len = 0: skip the k_len term).
- Counters never wrap: k counter width LEN_W, and the maximum k_len is 2^LEN_W−1.
- Stalls (i_mem_valid low, i_mul_ready low) hold state, counters and outputs indefinitely.

## Structure
- Package conv_pkg holds:
  - typedef enum logic [2:0] conv_seq_state_e;
  - localparam-free helper function for index width.
- One sub-module: conv_beat_cnt (parametrised-width counter with clear, increment, and terminal-compare output), instantiated twice (M0 and kernel).

## Test plan
- M0_WORDS=2, i_k_len=4, zero-wait handshakes → o_enb_m0 idx 0,1; o_enb_cn once; o_enb_k idx 0..3; o_done exactly 12 cycles after i_begin.
- i_k_len=0 → no o_enb_k, o_done one cycle after the CN beat.
- i_mul_ready held low 5 cycles in EVAL_IW → o_mul_valid held high; i_mul_done pulsed before acceptance is ignored; result is captured once.
- Random i_mem_valid gaps (50%) with i_k_len=9 → exactly 9 o_enb_k pulses with contiguous indices, no duplicates.
- i_abort mid READ_K (after idx 3) → IDLE next cycle, no o_done; a following i_begin restarts with idx 0.
- rst asserted asynchronously mid READ_M0 → all outputs 0 immediately, o_busy 0.
